// File: rtl/key_event_gen.sv
// Debounced N-channel button scanner with auto-repeat pulses and a one-deep,
// priority-encoded event register (lowest channel first, press > repeat > release).
module key_event_gen #(
  parameter int N          = 20,
  parameter int DB_CYCLES  = 4,
  parameter int RPT_DELAY  = 8,
  parameter int RPT_PERIOD = 4,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  button_i,
  input  logic          repeat_en_i,
  output logic [N-1:0]  pressed_o,
  output logic [N-1:0]  press_o,
  output logic [N-1:0]  release_o,
  output logic [N-1:0]  repeat_o,
  output logic          ev_valid_o,
  output logic [CW-1:0] ev_code_o,
  output logic [1:0]    ev_type_o,
  input  logic          ev_ready_i,
  output logic          ev_lost_o
);

  localparam int DBW  = $clog2(DB_CYCLES + 1);
  localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic           sync1_q, sync2_q;
    logic           pressed_q, pressed_d;
    logic           press_q, press_d, release_q, release_d;
    logic [DBW-1:0] db_q, db_d;
    logic [RW-1:0]  rc_q, rc_d;
    logic           rph_q, rph_d;
    logic           rpt;

    always_comb begin
      db_d      = '0;
      pressed_d = pressed_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync2_q != pressed_q) begin
        if (db_q == DBW'(DB_CYCLES - 1)) begin
          pressed_d = sync2_q;
          press_d   = sync2_q;
          release_d = ~sync2_q;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      // rc_q counts cycles since the press (or enable) cycle; rph_q marks the periodic phase
      rpt   = pressed_q & repeat_en_i & (rc_q == (rph_q ? RW'(RPT_PERIOD) : RW'(RPT_DELAY)));
      rc_d  = '0;
      rph_d = 1'b0;
      if (pressed_q && repeat_en_i) begin
        rph_d = rph_q | rpt;
        rc_d  = rpt ? RW'(1) : rc_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        db_q      <= '0;
        rc_q      <= '0;
        rph_q     <= 1'b0;
      end else begin
        sync1_q   <= button_i[gi];
        sync2_q   <= sync1_q;
        pressed_q <= pressed_d;
        press_q   <= press_d;
        release_q <= release_d;
        db_q      <= db_d;
        rc_q      <= rc_d;
        rph_q     <= rph_d;
      end
    end

    assign pressed_o[gi] = pressed_q;
    assign press_o[gi]   = press_q;
    assign release_o[gi] = release_q;
    assign repeat_o[gi]  = rpt;
  end

  logic [N-1:0]  pend_p_q, pend_r_q, pend_l_q;
  logic [N-1:0]  pend_p_d, pend_r_d, pend_l_d;
  logic [N-1:0]  clr_p, clr_r, clr_l;
  logic          load, sel_found;
  logic [CW-1:0] sel_code;
  logic [1:0]    sel_type;
  logic          ev_valid_q, ev_valid_d;
  logic [CW-1:0] ev_code_q, ev_code_d;
  logic [1:0]    ev_type_q, ev_type_d;
  logic          lost_q, lost_d;

  always_comb begin
    load      = ~ev_valid_q | ev_ready_i;
    sel_found = 1'b0;
    sel_code  = '0;
    sel_type  = 2'b00;
    // Scan downwards so the lowest pending channel wins
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_p_q[i] | pend_r_q[i] | pend_l_q[i]) begin
        sel_found = 1'b1;
        sel_code  = CW'(i);
        sel_type  = pend_p_q[i] ? 2'b01 : (pend_r_q[i] ? 2'b11 : 2'b10);
      end
    end
    clr_p = '0;
    clr_r = '0;
    clr_l = '0;
    if (load && sel_found) begin
      case (sel_type)
        2'b01:   clr_p[sel_code] = 1'b1;
        2'b11:   clr_r[sel_code] = 1'b1;
        default: clr_l[sel_code] = 1'b1;
      endcase
    end
    pend_p_d = (pend_p_q & ~clr_p) | press_o;
    pend_r_d = (pend_r_q & ~clr_r) | repeat_o;
    pend_l_d = (pend_l_q & ~clr_l) | release_o;
    lost_d   = |((press_o & pend_p_q & ~clr_p) | (repeat_o & pend_r_q & ~clr_r) |
                 (release_o & pend_l_q & ~clr_l));
    ev_valid_d = ev_valid_q;
    ev_code_d  = ev_code_q;
    ev_type_d  = ev_type_q;
    if (load) begin
      ev_valid_d = sel_found;
      ev_code_d  = sel_code;
      ev_type_d  = sel_type;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_p_q   <= '0;
      pend_r_q   <= '0;
      pend_l_q   <= '0;
      ev_valid_q <= 1'b0;
      ev_code_q  <= '0;
      ev_type_q  <= 2'b00;
      lost_q     <= 1'b0;
    end else begin
      pend_p_q   <= pend_p_d;
      pend_r_q   <= pend_r_d;
      pend_l_q   <= pend_l_d;
      ev_valid_q <= ev_valid_d;
      ev_code_q  <= ev_code_d;
      ev_type_q  <= ev_type_d;
      lost_q     <= lost_d;
    end
  end

  assign ev_valid_o = ev_valid_q;
  assign ev_code_o  = ev_code_q;
  assign ev_type_o  = ev_type_q;
  assign ev_lost_o  = lost_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen: directed scenarios plus random
// stimulus, all compared against a sample-history/timestamp reference model.
module tb_key_event_gen;
  localparam int N  = 20;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 4;
  localparam int CW = 5;
  localparam int VW = 4 * N + CW + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  button;
  logic          repeat_en, ev_ready;
  logic [N-1:0]  pressed, press, rel, rpt;
  logic          ev_valid, ev_lost;
  logic [CW-1:0] ev_code;
  logic [1:0]    ev_type;

  key_event_gen #(.N(N), .DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .button_i(button), .repeat_en_i(repeat_en),
    .pressed_o(pressed), .press_o(press), .release_o(rel), .repeat_o(rpt),
    .ev_valid_o(ev_valid), .ev_code_o(ev_code), .ev_type_o(ev_type),
    .ev_ready_i(ev_ready), .ev_lost_o(ev_lost)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  // Reference model state
  logic [N-1:0]  m_s1, m_s2, m_pressed, m_press, m_rel, m_rpt;
  logic [N-1:0]  m_pp, m_pr, m_pl;
  logic [31:0]   m_hist [N];
  int            m_tstart [N];
  bit            m_act [N];
  logic          m_ev_valid, m_lost;
  logic [CW-1:0] m_ev_code;
  logic [1:0]    m_ev_type;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_pressed = '0; m_press = '0; m_rel = '0; m_rpt = '0;
    m_pp = '0; m_pr = '0; m_pl = '0;
    m_ev_valid = 1'b0; m_lost = 1'b0; m_ev_code = '0; m_ev_type = 2'b00;
    for (int i = 0; i < N; i++) begin
      m_hist[i] = '0; m_tstart[i] = 0; m_act[i] = 1'b0;
    end
  endtask

  // Called once per cycle at the falling edge: repeat pulses from time since activation
  task automatic sample();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      bit act;
      int k;
      act = m_pressed[i] && repeat_en;
      if (act && !m_act[i]) m_tstart[i] = cyc_n;
      k = cyc_n - m_tstart[i];
      m_rpt[i] = act && (k >= RD) && (((k - RD) % RP) == 0);
      m_act[i] = act;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] cp, cr, cl;
    logic [31:0]  mask;
    bit           found, flip;
    cp = '0; cr = '0; cl = '0; found = 0;
    if (!m_ev_valid || ev_ready) begin
      m_ev_code = '0; m_ev_type = 2'b00;
      for (int i = 0; i < N && !found; i++) begin
        if (m_pp[i])      begin found = 1; cp[i] = 1'b1; m_ev_type = 2'b01; m_ev_code = CW'(i); end
        else if (m_pr[i]) begin found = 1; cr[i] = 1'b1; m_ev_type = 2'b11; m_ev_code = CW'(i); end
        else if (m_pl[i]) begin found = 1; cl[i] = 1'b1; m_ev_type = 2'b10; m_ev_code = CW'(i); end
      end
      m_ev_valid = found;
    end
    m_lost = |((m_press & m_pp & ~cp) | (m_rpt & m_pr & ~cr) | (m_rel & m_pl & ~cl));
    m_pp = (m_pp & ~cp) | m_press;
    m_pr = (m_pr & ~cr) | m_rpt;
    m_pl = (m_pl & ~cl) | m_rel;
    mask = (32'd1 << DB) - 32'd1;
    for (int i = 0; i < N; i++) begin
      m_hist[i] = {m_hist[i][30:0], m_s2[i]};
      flip = ((m_hist[i] ^ {32{m_pressed[i]}}) & mask) == mask;
      m_press[i] = flip && !m_pressed[i];
      m_rel[i]   = flip && m_pressed[i];
      if (flip) m_pressed[i] = ~m_pressed[i];
    end
    m_s2 = m_s1;
    m_s1 = button;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    cyc_n++;
    #1;
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {pressed, press, rel, rpt, ev_valid, (ev_valid ? ev_code : CW'(0)),
            (ev_valid ? ev_type : 2'b00), ev_lost};
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    return {m_pressed, m_press, m_rel, m_rpt, m_ev_valid, (m_ev_valid ? m_ev_code : CW'(0)),
            (m_ev_valid ? m_ev_type : 2'b00), m_lost};
  endfunction

  task automatic test_reset();
    #1;
    vectors++;
    if (dut_vec() !== '0) begin
      miscompares++;
      $display("FAIL reset_async got %h expected 0", dut_vec());
    end
    for (int k = 0; k < 3; k++) begin
      sample();
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL reset_hold k=%0d got %h expected %h", k, dut_vec(), mdl_vec());
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_press();
    ev_ready = 1'b1;
    button[3] = 1'b1;
    for (int k = 0; k <= 34; k++) begin
      if (k == 21) button[3] = 1'b0;
      sample();
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL press_model k=%0d got %h expected %h", k, dut_vec(), mdl_vec());
      end
      vectors++;
      if ({pressed[3], press[3], rel[3], ev_valid} !==
          {(k >= 6 && k < 27), (k == 6), (k == 27), (k == 8 || k == 29)}) begin
        miscompares++;
        $display("FAIL press_timing k=%0d got %b expected %b", k, {pressed[3], press[3], rel[3], ev_valid},
                 {(k >= 6 && k < 27), (k == 6), (k == 27), (k == 8 || k == 29)});
      end
      if (k == 8 || k == 29) begin
        vectors++;
        if ({ev_code, ev_type} !== {CW'(3), (k == 8) ? 2'b01 : 2'b10}) begin
          miscompares++;
          $display("FAIL press_event k=%0d got code=%0d type=%b", k, ev_code, ev_type);
        end
      end
      advance();
    end
  endtask

  task automatic test_glitch();
    button[5] = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      if (k == 3) button[5] = 1'b0;
      sample();
      vectors++;
      if ({pressed, press, ev_valid} !== '0 || dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL glitch k=%0d got %h expected %h", k, dut_vec(), mdl_vec());
      end
      advance();
    end
  endtask

  task automatic test_repeat();
    logic [15:0] got;
    int          n_ev;
    got = '0; n_ev = 0;
    repeat_en = 1'b1;
    ev_ready = 1'b1;
    button[0] = 1'b1;
    for (int k = 0; k <= 34; k++) begin
      if (k == 20) button[0] = 1'b0;
      sample();
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL repeat_model k=%0d got %h expected %h", k, dut_vec(), mdl_vec());
      end
      vectors++;
      if ({rpt[0], rel[0]} !== {(k == 14 || k == 18 || k == 22), (k == 26)}) begin
        miscompares++;
        $display("FAIL repeat_timing k=%0d got rpt=%b rel=%b", k, rpt[0], rel[0]);
      end
      if (ev_valid && ev_ready) begin
        got = {got[13:0], ev_type};
        n_ev++;
      end
      advance();
    end
    vectors++;
    if (n_ev != 5 || got[9:0] !== 10'b01_11_11_11_10) begin
      miscompares++;
      $display("FAIL repeat_order got n=%0d types=%b expected n=5 types=0111111110", n_ev, got[9:0]);
    end
    repeat_en = 1'b0;
  endtask

  task automatic test_priority();
    ev_ready = 1'b0;
    button[7] = 1'b1;
    button[2] = 1'b1;
    for (int k = 0; k <= 34; k++) begin
      if (k == 12) ev_ready = 1'b1;
      if (k == 13) ev_ready = 1'b0;
      if (k == 16) begin ev_ready = 1'b1; button[7] = 1'b0; button[2] = 1'b0; end
      sample();
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL priority_model k=%0d got %h expected %h", k, dut_vec(), mdl_vec());
      end
      if (k >= 8 && k <= 15) begin
        vectors++;
        if ({ev_valid, ev_code, ev_type} !== {1'b1, (k <= 12) ? CW'(2) : CW'(7), 2'b01}) begin
          miscompares++;
          $display("FAIL priority_hold k=%0d got v=%b code=%0d type=%b", k, ev_valid, ev_code, ev_type);
        end
      end
      advance();
    end
  endtask

  task automatic test_lost();
    ev_ready = 1'b0;
    repeat_en = 1'b1;
    button[1] = 1'b1;
    for (int k = 0; k <= 42; k++) begin
      if (k == 21) repeat_en = 1'b0;
      if (k == 22) begin ev_ready = 1'b1; button[1] = 1'b0; end
      sample();
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL lost_model k=%0d got %h expected %h", k, dut_vec(), mdl_vec());
      end
      vectors++;
      if (ev_lost !== (k == 19)) begin
        miscompares++;
        $display("FAIL lost_pulse k=%0d got %b expected %b", k, ev_lost, (k == 19));
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    ev_ready = 1'b0;
    button[4] = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      if (k == 10) button[9] = 1'b1;
      if (k == 14) begin
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (dut_vec() !== '0) begin
          miscompares++;
          $display("FAIL reset_mid_async got %h expected 0", dut_vec());
        end
      end
      if (k == 16) begin rst = 1'b0; ev_ready = 1'b1; end
      if (k == 34) begin button[4] = 1'b0; button[9] = 1'b0; end
      sample();
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL reset_mid_model k=%0d got %h expected %h", k, dut_vec(), mdl_vec());
      end
      if (k == 13 || k >= 17 && k <= 25) begin
        vectors++;
        if ({ev_valid, press[9], press[4]} !== {(k == 13 || k == 24 || k == 25), (k == 22), (k == 22)}) begin
          miscompares++;
          $display("FAIL reset_mid_press k=%0d got v=%b p9=%b p4=%b", k, ev_valid, press[9], press[4]);
        end
      end
      if (k == 24 || k == 25) begin
        vectors++;
        if (ev_code !== ((k == 24) ? CW'(4) : CW'(9))) begin
          miscompares++;
          $display("FAIL reset_mid_code k=%0d got %0d expected %0d", k, ev_code, (k == 24) ? 4 : 9);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    int idx;
    for (int k = 0; k < 1500; k++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(499, 0) == 0) begin rst = 1'b1; model_reset(); end
      if ($urandom_range(9, 0) < 4) begin
        idx = int'($urandom_range(N - 1, 0));
        button[idx] = ~button[idx];
      end
      if ($urandom_range(39, 0) == 0) repeat_en = ~repeat_en;
      ev_ready = ($urandom_range(3, 0) != 0);
      sample();
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL random k=%0d got %h expected %h", k, dut_vec(), mdl_vec());
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    button = '0;
    repeat_en = 1'b0;
    ev_ready = 1'b1;
    model_reset();
    test_reset();
    test_press();
    test_glitch();
    test_repeat();
    test_priority();
    test_lost();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
